tl_xbar_nm: RTL and testbench

N-master to single-slave TileLink-UL crossbar, the parametrised successor to the single-master main crossbar. It sits between NUM_MASTERS host ports and the downstream port that feeds the CDC adapter. It round-robin arbitrates Channel A into a registered output stage and tags each request's source with the master index. Channel D responses are routed back to the master by that tag, and a per-master outstanding-request limit is enforced.

---
 rtl/tl_xbar_nm_if.sv | 76 +++++++
 rtl/tl_xbar_nm.sv | 173 +++++++++++++++++
 tb/tb_tl_xbar_nm.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tl_xbar_nm_if.sv
// Bus bundle for tl_xbar_nm: flattened upstream TileLink-UL ports (master i owns slice i)
// plus the single downstream port; the crossbar binds the slave modport.
interface tl_xbar_nm_if #(
  parameter int NUM_MASTERS  = 2,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int SIZE_WIDTH   = 3,
  parameter int OPCODE_WIDTH = 3,
  parameter int PARAM_WIDTH  = 3,
  parameter int SRC_WIDTH    = 1,
  parameter int SINK_WIDTH   = 1
);
  localparam int MASK_WIDTH = DATA_WIDTH / 8;
  localparam int MIDX_W     = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int DSRC_W     = SRC_WIDTH + MIDX_W;

  logic [NUM_MASTERS-1:0]              a_valid;
  logic [NUM_MASTERS-1:0]              a_ready;
  logic [NUM_MASTERS*OPCODE_WIDTH-1:0] a_opcode;
  logic [NUM_MASTERS*PARAM_WIDTH-1:0]  a_param;
  logic [NUM_MASTERS*SIZE_WIDTH-1:0]   a_size;
  logic [NUM_MASTERS*SRC_WIDTH-1:0]    a_source;
  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   a_address;
  logic [NUM_MASTERS*MASK_WIDTH-1:0]   a_mask;
  logic [NUM_MASTERS*DATA_WIDTH-1:0]   a_data;

  logic [NUM_MASTERS-1:0]  d_valid;
  logic [NUM_MASTERS-1:0]  d_ready;
  logic [OPCODE_WIDTH-1:0] d_opcode;
  logic [PARAM_WIDTH-1:0]  d_param;
  logic [SIZE_WIDTH-1:0]   d_size;
  logic [SRC_WIDTH-1:0]    d_source;
  logic [SINK_WIDTH-1:0]   d_sink;
  logic [DATA_WIDTH-1:0]   d_data;
  logic                    d_error;

  logic                    a_valid_out;
  logic                    a_ready_out;
  logic [OPCODE_WIDTH-1:0] a_opcode_out;
  logic [PARAM_WIDTH-1:0]  a_param_out;
  logic [SIZE_WIDTH-1:0]   a_size_out;
  logic [DSRC_W-1:0]       a_source_out;
  logic [ADDR_WIDTH-1:0]   a_address_out;
  logic [MASK_WIDTH-1:0]   a_mask_out;
  logic [DATA_WIDTH-1:0]   a_data_out;

  logic                    d_valid_in;
  logic                    d_ready_in;
  logic [OPCODE_WIDTH-1:0] d_opcode_in;
  logic [PARAM_WIDTH-1:0]  d_param_in;
  logic [SIZE_WIDTH-1:0]   d_size_in;
  logic [DSRC_W-1:0]       d_source_in;
  logic [SINK_WIDTH-1:0]   d_sink_in;
  logic [DATA_WIDTH-1:0]   d_data_in;
  logic                    d_error_in;

  logic                    err_unmapped;

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
    output a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error,
    output a_valid_out, a_opcode_out, a_param_out, a_size_out, a_source_out, a_address_out,
           a_mask_out, a_data_out, d_ready_in, err_unmapped,
    input  a_ready_out, d_valid_in, d_opcode_in, d_param_in, d_size_in, d_source_in,
           d_sink_in, d_data_in, d_error_in
  );

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
    input  a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error,
    input  a_valid_out, a_opcode_out, a_param_out, a_size_out, a_source_out, a_address_out,
           a_mask_out, a_data_out, d_ready_in, err_unmapped,
    output a_ready_out, d_valid_in, d_opcode_in, d_param_in, d_size_in, d_source_in,
           d_sink_in, d_data_in, d_error_in
  );
endinterface

// File: rtl/tl_xbar_nm.sv
// N-master to one-slave TileLink-UL crossbar: round-robin Channel A into a one-entry
// output register with master-tagged source, tag-routed Channel D, per-master credit limit.
module tl_xbar_nm #(
  parameter int NUM_MASTERS  = 2,
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int SIZE_WIDTH   = 3,
  parameter int OPCODE_WIDTH = 3,
  parameter int PARAM_WIDTH  = 3,
  parameter int SRC_WIDTH    = 1,
  parameter int SINK_WIDTH   = 1,
  parameter int MAX_OUT      = 4
) (
  input logic        clk,
  input logic        reset,
  tl_xbar_nm_if.slave bus
);
  localparam int MASK_WIDTH = DATA_WIDTH / 8;
  localparam int MIDX_W     = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int DSRC_W     = SRC_WIDTH + MIDX_W;
  localparam int CNT_W      = $clog2(MAX_OUT + 1);

  logic                    r_a_valid_p0;
  logic [OPCODE_WIDTH-1:0] r_opcode_p0;
  logic [PARAM_WIDTH-1:0]  r_param_p0;
  logic [SIZE_WIDTH-1:0]   r_size_p0;
  logic [DSRC_W-1:0]       r_source_p0;
  logic [ADDR_WIDTH-1:0]   r_address_p0;
  logic [MASK_WIDTH-1:0]   r_mask_p0;
  logic [DATA_WIDTH-1:0]   r_data_p0;
  logic [MIDX_W-1:0]       r_rr_ptr;
  logic [CNT_W-1:0]        r_cnt [NUM_MASTERS];

  logic                    w_slot_free;
  logic                    w_grant_vld;
  logic [MIDX_W-1:0]       w_grant_idx;
  logic [MIDX_W-1:0]       w_rr_next;
  logic [NUM_MASTERS-1:0]  w_elig;
  logic [NUM_MASTERS-1:0]  w_a_ready;
  logic [NUM_MASTERS-1:0]  w_d_valid;
  logic [NUM_MASTERS-1:0]  w_d_hs;
  logic                    w_d_ready_in;
  logic [MIDX_W-1:0]       w_d_idx;
  logic                    w_d_mapped;
  logic [OPCODE_WIDTH-1:0] w_sel_opcode;
  logic [PARAM_WIDTH-1:0]  w_sel_param;
  logic [SIZE_WIDTH-1:0]   w_sel_size;
  logic [SRC_WIDTH-1:0]    w_sel_source;
  logic [ADDR_WIDTH-1:0]   w_sel_address;
  logic [MASK_WIDTH-1:0]   w_sel_mask;
  logic [DATA_WIDTH-1:0]   w_sel_data;

  assign w_slot_free = !r_a_valid_p0 || bus.a_ready_out;

  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++)
      w_elig[i] = bus.a_valid[i] && (r_cnt[i] < CNT_W'(MAX_OUT));
  end

  // First eligible master at or after the round-robin pointer, wrapping upward.
  always_comb begin
    int m;
    m           = 0;
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      m = (int'(r_rr_ptr) + k) % NUM_MASTERS;
      if (!w_grant_vld && w_elig[m]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = MIDX_W'(m);
      end
    end
  end

  assign w_rr_next = MIDX_W'((int'(w_grant_idx) + 1) % NUM_MASTERS);

  always_comb begin
    w_sel_opcode  = '0;
    w_sel_param   = '0;
    w_sel_size    = '0;
    w_sel_source  = '0;
    w_sel_address = '0;
    w_sel_mask    = '0;
    w_sel_data    = '0;
    w_a_ready     = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (w_grant_idx == MIDX_W'(i)) begin
        w_sel_opcode  = bus.a_opcode[i*OPCODE_WIDTH +: OPCODE_WIDTH];
        w_sel_param   = bus.a_param[i*PARAM_WIDTH +: PARAM_WIDTH];
        w_sel_size    = bus.a_size[i*SIZE_WIDTH +: SIZE_WIDTH];
        w_sel_source  = bus.a_source[i*SRC_WIDTH +: SRC_WIDTH];
        w_sel_address = bus.a_address[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_mask    = bus.a_mask[i*MASK_WIDTH +: MASK_WIDTH];
        w_sel_data    = bus.a_data[i*DATA_WIDTH +: DATA_WIDTH];
        w_a_ready[i]  = reset && w_slot_free && w_grant_vld;
      end
    end
  end

  // D routing by the master tag; tags beyond NUM_MASTERS are sunk and flagged.
  assign w_d_idx    = (NUM_MASTERS == 1) ? '0 : bus.d_source_in[DSRC_W-1:SRC_WIDTH];
  assign w_d_mapped = (int'(w_d_idx) < NUM_MASTERS);

  always_comb begin
    w_d_valid    = '0;
    w_d_ready_in = 1'b1;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (w_d_mapped && (w_d_idx == MIDX_W'(i))) begin
        w_d_valid[i] = bus.d_valid_in;
        w_d_ready_in = bus.d_ready[i];
      end
    end
  end

  assign w_d_hs = w_d_valid & bus.d_ready;

  // Stage p0: registered A output slot, arbitration pointer and credit counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a_valid_p0 <= 1'b0;
      r_opcode_p0  <= '0;
      r_param_p0   <= '0;
      r_size_p0    <= '0;
      r_source_p0  <= '0;
      r_address_p0 <= '0;
      r_mask_p0    <= '0;
      r_data_p0    <= '0;
      r_rr_ptr     <= '0;
      for (int i = 0; i < NUM_MASTERS; i++) r_cnt[i] <= '0;
    end else begin
      if (w_slot_free) begin
        r_a_valid_p0 <= w_grant_vld;
        if (w_grant_vld) begin
          r_opcode_p0  <= w_sel_opcode;
          r_param_p0   <= w_sel_param;
          r_size_p0    <= w_sel_size;
          r_source_p0  <= {w_grant_idx, w_sel_source};
          r_address_p0 <= w_sel_address;
          r_mask_p0    <= w_sel_mask;
          r_data_p0    <= w_sel_data;
          r_rr_ptr     <= w_rr_next;
        end
      end
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (w_a_ready[i] && !w_d_hs[i])
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        else if (!w_a_ready[i] && w_d_hs[i] && (r_cnt[i] != '0))
          r_cnt[i] <= r_cnt[i] - CNT_W'(1);
      end
    end
  end

  assign bus.a_ready       = w_a_ready;
  assign bus.a_valid_out   = r_a_valid_p0;
  assign bus.a_opcode_out  = r_opcode_p0;
  assign bus.a_param_out   = r_param_p0;
  assign bus.a_size_out    = r_size_p0;
  assign bus.a_source_out  = r_source_p0;
  assign bus.a_address_out = r_address_p0;
  assign bus.a_mask_out    = r_mask_p0;
  assign bus.a_data_out    = r_data_p0;

  assign bus.d_valid       = w_d_valid;
  assign bus.d_ready_in    = w_d_ready_in;
  assign bus.d_opcode      = bus.d_opcode_in;
  assign bus.d_param       = bus.d_param_in;
  assign bus.d_size        = bus.d_size_in;
  assign bus.d_source      = bus.d_source_in[SRC_WIDTH-1:0];
  assign bus.d_sink        = bus.d_sink_in;
  assign bus.d_data        = bus.d_data_in;
  assign bus.d_error       = bus.d_error_in;
  assign bus.err_unmapped  = bus.d_valid_in && !w_d_mapped;
endmodule

// File: tb/tb_tl_xbar_nm.sv
// Scoreboard bench for tl_xbar_nm: a 2-master instance (credit limit 2) and a 3-master
// instance; directed stimulus pushes expected beats, monitors pop and compare.
module tb_tl_xbar_nm;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  tl_xbar_nm_if #(.NUM_MASTERS(2)) ifa ();
  tl_xbar_nm_if #(.NUM_MASTERS(3)) ifb ();

  tl_xbar_nm #(.NUM_MASTERS(2), .MAX_OUT(2)) u_a (.clk(clk), .reset(rst_n), .bus(ifa));
  tl_xbar_nm #(.NUM_MASTERS(3), .MAX_OUT(2)) u_b (.clk(clk), .reset(rst_n), .bus(ifb));

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  src;
    logic [31:0] data;
    bit          gap;
  } a_exp_t;

  typedef struct {
    logic [1:0]  vld;
    logic        rdy;
    logic        src;
    logic [31:0] data;
  } d_exp_t;

  a_exp_t qa[$];
  a_exp_t qb[$];
  d_exp_t qd[$];
  a_exp_t ea, eb;
  d_exp_t ed;
  int     last_a = -10;
  int     last_b = -10;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [31:0] addr, input logic [2:0] src, input logic [31:0] data,
                        input bit gap);
    a_exp_t e;
    e.addr = addr; e.src = src; e.data = data; e.gap = gap;
    qa.push_back(e);
  endtask

  task automatic push_b(input logic [31:0] addr, input logic [2:0] src, input logic [31:0] data,
                        input bit gap);
    a_exp_t e;
    e.addr = addr; e.src = src; e.data = data; e.gap = gap;
    qb.push_back(e);
  endtask

  task automatic push_d(input logic [1:0] vld, input logic rdy, input logic src,
                        input logic [31:0] data);
    d_exp_t e;
    e.vld = vld; e.rdy = rdy; e.src = src; e.data = data;
    qd.push_back(e);
  endtask

  task automatic set_ma(input int m, input logic [31:0] addr, input logic src, input logic [31:0] data);
    ifa.a_address[m*32 +: 32] = addr;
    ifa.a_source[m]           = src;
    ifa.a_data[m*32 +: 32]    = data;
  endtask

  task automatic set_mb(input int m, input logic [31:0] addr, input logic src, input logic [31:0] data);
    ifb.a_address[m*32 +: 32] = addr;
    ifb.a_source[m]           = src;
    ifb.a_data[m*32 +: 32]    = data;
  endtask

  task automatic idle_inputs;
    ifa.a_valid = '0; ifa.a_opcode = '0; ifa.a_param = '0; ifa.a_size = '0;
    ifa.a_source = '0; ifa.a_address = '0; ifa.a_mask = '0; ifa.a_data = '0;
    ifa.d_ready = '0; ifa.a_ready_out = 1'b1; ifa.d_valid_in = 1'b0;
    ifa.d_opcode_in = '0; ifa.d_param_in = '0; ifa.d_size_in = '0; ifa.d_source_in = '0;
    ifa.d_sink_in = '0; ifa.d_data_in = '0; ifa.d_error_in = 1'b0;
    ifb.a_valid = '0; ifb.a_opcode = '0; ifb.a_param = '0; ifb.a_size = '0;
    ifb.a_source = '0; ifb.a_address = '0; ifb.a_mask = '0; ifb.a_data = '0;
    ifb.d_ready = '0; ifb.a_ready_out = 1'b1; ifb.d_valid_in = 1'b0;
    ifb.d_opcode_in = '0; ifb.d_param_in = '0; ifb.d_size_in = '0; ifb.d_source_in = '0;
    ifb.d_sink_in = '0; ifb.d_data_in = '0; ifb.d_error_in = 1'b0;
  endtask

  task automatic reset_pulse;
    ifa.a_valid = '0;
    ifb.a_valid = '0;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
  endtask

  // Downstream A monitor, instance a
  always @(negedge clk) begin
    if (rst_n && ifa.a_valid_out && ifa.a_ready_out) begin
      if (qa.size() == 0) begin
        total++; bad++;
        $display("FAIL a_extra_beat: got addr %0h src %0h, expected no beat", ifa.a_address_out,
                 ifa.a_source_out);
      end else begin
        ea = qa.pop_front();
        check("a_addr", ifa.a_address_out, ea.addr);
        check("a_src", ifa.a_source_out, ea.src);
        check("a_data", ifa.a_data_out, ea.data);
        if (ea.gap) check("a_gap", cyc - last_a, 1);
        last_a = cyc;
      end
    end
  end

  // Downstream A monitor, instance b
  always @(negedge clk) begin
    if (rst_n && ifb.a_valid_out && ifb.a_ready_out) begin
      if (qb.size() == 0) begin
        total++; bad++;
        $display("FAIL b_extra_beat: got addr %0h src %0h, expected no beat", ifb.a_address_out,
                 ifb.a_source_out);
      end else begin
        eb = qb.pop_front();
        check("b_addr", ifb.a_address_out, eb.addr);
        check("b_src", ifb.a_source_out, eb.src);
        check("b_data", ifb.a_data_out, eb.data);
        if (eb.gap) check("b_gap", cyc - last_b, 1);
        last_b = cyc;
      end
    end
  end

  // Channel D monitor, instance a
  always @(negedge clk) begin
    if (rst_n && ifa.d_valid_in) begin
      if (qd.size() == 0) begin
        total++; bad++;
        $display("FAIL d_extra_beat: got d_valid %0b, expected no beat", ifa.d_valid);
      end else begin
        ed = qd.pop_front();
        check("d_valid", ifa.d_valid, ed.vld);
        check("d_ready_in", ifa.d_ready_in, ed.rdy);
        check("d_source", ifa.d_source, ed.src);
        check("d_data", ifa.d_data, ed.data);
        check("d_err", ifa.err_unmapped, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    ifa.a_valid     = 2'b11;
    ifa.d_valid_in  = 1'b1;
    ifa.d_source_in = 2'b01;
    tick; tick;
    @(negedge clk);
    check("rst_a_ready", ifa.a_ready, 2'b00);
    check("rst_a_valid_out", ifa.a_valid_out, 0);
    check("rst_a_addr_out", ifa.a_address_out, 0);
    check("rst_d_valid", ifa.d_valid, 2'b01);
    tick;
    ifa.a_valid    = '0;
    ifa.d_valid_in = 1'b0;
    rst_n          = 1'b1;
    tick;

    // Round-robin alternation with both masters pending
    set_ma(0, 32'hA000_0000, 1'b0, 32'h1111_0000);
    set_ma(1, 32'hB000_0000, 1'b0, 32'h2222_0000);
    push_a(32'hA000_0000, 3'b000, 32'h1111_0000, 1'b0);
    push_a(32'hB000_0000, 3'b010, 32'h2222_0000, 1'b1);
    push_a(32'hA000_0000, 3'b000, 32'h1111_0000, 1'b1);
    push_a(32'hB000_0000, 3'b010, 32'h2222_0000, 1'b1);
    ifa.a_valid = 2'b11;
    repeat (6) tick;
    @(negedge clk);
    check("rr_credit_stall", ifa.a_ready, 2'b00);
    check("rr_out_idle", ifa.a_valid_out, 0);
    tick;
    reset_pulse();

    // One-cycle A latency, master-tagged source
    set_ma(1, 32'h1000_0040, 1'b1, 32'hDEAD_BEEF);
    push_a(32'h1000_0040, 3'b011, 32'hDEAD_BEEF, 1'b0);
    ifa.a_valid = 2'b10;
    @(negedge clk);
    check("lat_a_ready", ifa.a_ready, 2'b10);
    check("lat_pre_valid_out", ifa.a_valid_out, 0);
    tick;
    ifa.a_valid = '0;
    @(negedge clk);
    check("lat_valid_out", ifa.a_valid_out, 1);
    check("lat_src_out", ifa.a_source_out, 2'b11);
    check("lat_addr_out", ifa.a_address_out, 32'h1000_0040);
    tick;

    // Downstream backpressure holds the slot and the pointer
    ifa.a_ready_out = 1'b0;
    set_ma(0, 32'hC000_0000, 1'b0, 32'h3333_0000);
    set_ma(1, 32'hD000_0000, 1'b1, 32'h4444_0000);
    push_a(32'hC000_0000, 3'b000, 32'h3333_0000, 1'b0);
    push_a(32'hD000_0000, 3'b011, 32'h4444_0000, 1'b1);
    ifa.a_valid = 2'b01;
    tick;
    ifa.a_valid = 2'b11;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check("stall_a_ready", ifa.a_ready, 2'b00);
      check("stall_valid_out", ifa.a_valid_out, 1);
      check("stall_addr_out", ifa.a_address_out, 32'hC000_0000);
      tick;
    end
    ifa.a_ready_out = 1'b1;
    @(negedge clk);
    check("drain_grant", ifa.a_ready, 2'b10);
    tick;
    ifa.a_valid = '0;
    tick; tick;
    reset_pulse();

    // Credit limit: third request waits for a response
    set_ma(0, 32'hE000_0000, 1'b0, 32'h5555_0000);
    push_a(32'hE000_0000, 3'b000, 32'h5555_0000, 1'b0);
    push_a(32'hE000_0000, 3'b000, 32'h5555_0000, 1'b1);
    push_a(32'hE000_0000, 3'b000, 32'h5555_0000, 1'b0);
    ifa.a_valid = 2'b01;
    tick; tick;
    @(negedge clk);
    check("maxout_stall", ifa.a_ready, 2'b00);
    tick;
    @(negedge clk);
    check("maxout_stall2", ifa.a_ready, 2'b00);
    tick;
    ifa.d_valid_in  = 1'b1;
    ifa.d_source_in = 2'b00;
    ifa.d_ready     = 2'b01;
    ifa.d_data_in   = 32'h0000_0077;
    push_d(2'b01, 1'b1, 1'b0, 32'h0000_0077);
    @(negedge clk);
    check("maxout_pre_release", ifa.a_ready, 2'b00);
    tick;
    ifa.d_valid_in = 1'b0;
    ifa.d_ready    = '0;
    @(negedge clk);
    check("maxout_release", ifa.a_ready, 2'b01);
    tick;
    ifa.a_valid = '0;
    tick; tick;

    // D held by master-side backpressure; also decrements an empty counter
    ifa.d_valid_in  = 1'b1;
    ifa.d_source_in = 2'b10;
    ifa.d_ready     = 2'b00;
    ifa.d_data_in   = 32'h0000_0088;
    push_d(2'b10, 1'b0, 1'b0, 32'h0000_0088);
    tick;
    push_d(2'b10, 1'b0, 1'b0, 32'h0000_0088);
    tick;
    ifa.d_ready = 2'b10;
    push_d(2'b10, 1'b1, 1'b0, 32'h0000_0088);
    tick;
    ifa.d_valid_in = 1'b0;
    ifa.d_ready    = '0;

    // Counter of master 1 saturated at zero, so it still has credit
    set_ma(1, 32'hF000_0000, 1'b1, 32'h6666_0000);
    push_a(32'hF000_0000, 3'b011, 32'h6666_0000, 1'b0);
    ifa.a_valid = 2'b10;
    @(negedge clk);
    check("sat_a_ready", ifa.a_ready, 2'b10);
    tick;
    ifa.a_valid = '0;
    tick; tick;

    // Three-master rotation and credit stall
    for (int i = 0; i < 3; i++) set_mb(i, 32'h100 * (i + 1), 1'b0, 32'hB0 + i);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 3; i++)
        push_b(32'h100 * (i + 1), 3'(i << 1), 32'hB0 + i, (r + i) != 0);
    ifb.a_valid = 3'b111;
    repeat (8) tick;
    @(negedge clk);
    check("b_credit_stall", ifb.a_ready, 3'b000);
    tick;
    ifb.a_valid = '0;
    tick;

    // Unroutable tag on the 3-master instance
    ifb.d_valid_in  = 1'b1;
    ifb.d_source_in = 3'b110;
    ifb.d_ready     = 3'b000;
    @(negedge clk);
    check("unmap_d_valid", ifb.d_valid, 3'b000);
    check("unmap_d_ready_in", ifb.d_ready_in, 1);
    check("unmap_err", ifb.err_unmapped, 1);
    tick;
    ifb.d_valid_in = 1'b0;
    @(negedge clk);
    check("unmap_err_clear", ifb.err_unmapped, 0);
    tick;
    ifb.d_valid_in  = 1'b1;
    ifb.d_source_in = 3'b101;
    ifb.d_ready     = 3'b100;
    @(negedge clk);
    check("route2_d_valid", ifb.d_valid, 3'b100);
    check("route2_d_ready_in", ifb.d_ready_in, 1);
    check("route2_d_source", ifb.d_source, 1);
    check("route2_err", ifb.err_unmapped, 0);
    tick;
    ifb.d_valid_in = 1'b0;
    ifb.d_ready    = '0;
    tick; tick;

    check("qa_left", qa.size(), 0);
    check("qb_left", qb.size(), 0);
    check("qd_left", qd.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
